vga_timing_ctrl: RTL and testbench

//   VGA raster timing generator and pixel-sink end of the pix_x/pix_y -> pix_data interface.

---
 rtl/vga_timing_ctrl.sv | 132 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: counts pixel/line positions, drives syncs, requests pixels one clk
// ahead via pix_x/pix_y and masks the reply onto rgb. Define VGA_COLOR_BAR_EN for internal colour bars.
module vga_timing_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_VALID  = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_VALID  = 480,
   parameter int V_FRONT  = 10,
   parameter int SYNC_NEG = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic        rgb_valid,
   output logic [15:0] rgb
);

   localparam int HT = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int VT = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HA = H_SYNC + H_BACK;
   localparam int VA = V_SYNC + V_BACK;

   if (HT > 1024) begin : g_bad_ht
      $error("vga_timing_ctrl: horizontal total exceeds 1024");
   end
   if (VT > 1024) begin : g_bad_vt
      $error("vga_timing_ctrl: vertical total exceeds 1024");
   end
   if (HA < 1) begin : g_bad_ha
      $error("vga_timing_ctrl: request lead needs H_SYNC+H_BACK >= 1");
   end

   localparam logic [9:0] C_HT_M1   = 10'(HT - 1);
   localparam logic [9:0] C_VT_M1   = 10'(VT - 1);
   localparam logic [9:0] C_H_SYNC  = 10'(H_SYNC);
   localparam logic [9:0] C_V_SYNC  = 10'(V_SYNC);
   localparam logic [9:0] C_HA      = 10'(HA);
   localparam logic [9:0] C_HA_M1   = 10'(HA - 1);
   localparam logic [9:0] C_HA_END  = 10'(HA + H_VALID - 1);
   localparam logic [9:0] C_REQ_END = 10'(HA + H_VALID - 2);
   localparam logic [9:0] C_VA      = 10'(VA);
   localparam logic [9:0] C_VA_END  = 10'(VA + V_VALID - 1);
   localparam logic       L_ACT     = 1'(SYNC_NEG == 0);

   logic [9:0] r_cnt_h;
   logic [9:0] r_cnt_v;
   logic       w_h_last;
   logic       w_v_last;
   logic       w_v_act;
   logic       w_h_act;
   logic       w_h_req;
   logic       w_req;

   assign w_h_last = (r_cnt_h == C_HT_M1);
   assign w_v_last = (r_cnt_v == C_VT_M1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt_h <= '0;
         r_cnt_v <= '0;
      end else begin
         if (w_h_last) begin
            r_cnt_h <= '0;
            if (w_v_last) begin
               r_cnt_v <= '0;
            end else begin
               r_cnt_v <= r_cnt_v + 10'd1;
            end
         end else begin
            r_cnt_h <= r_cnt_h + 10'd1;
         end
      end
   end

   // Every output below is a pure decode of the counters, so reset values appear asynchronously.
   assign hsync = (r_cnt_h < C_H_SYNC) ? L_ACT : ~L_ACT;
   assign vsync = (r_cnt_v < C_V_SYNC) ? L_ACT : ~L_ACT;

   assign w_v_act = (r_cnt_v >= C_VA) && (r_cnt_v <= C_VA_END);
   assign w_h_act = (r_cnt_h >= C_HA) && (r_cnt_h <= C_HA_END);
   assign w_h_req = (r_cnt_h >= C_HA_M1) && (r_cnt_h <= C_REQ_END);
   assign w_req   = w_v_act && w_h_req;

   assign rgb_valid = w_v_act && w_h_act;
   assign pix_x     = w_req ? (r_cnt_h - C_HA_M1) : 10'h3FF;
   assign pix_y     = w_req ? (r_cnt_v - C_VA) : 10'h3FF;

`ifdef VGA_COLOR_BAR_EN
   localparam int BAR_W  = H_VALID / 8;
   localparam int BAR_SH = $clog2(BAR_W);

   if ((BAR_W < 1) || ((1 << BAR_SH) != BAR_W)) begin : g_bad_bar
      $error("vga_timing_ctrl: H_VALID/8 must be a power of 2");
   end

   logic [9:0]  w_col;
   logic [9:0]  w_col_sh;
   logic [2:0]  w_bar;
   logic [15:0] w_bar_rgb;

   assign w_col    = r_cnt_h - C_HA;
   assign w_col_sh = w_col >> BAR_SH;
   assign w_bar    = w_col_sh[2:0];

   always_comb begin
      w_bar_rgb = 16'h0000;
      case (w_bar)
         3'd0:    w_bar_rgb = 16'hFFFF;
         3'd1:    w_bar_rgb = 16'hFFE0;
         3'd2:    w_bar_rgb = 16'h07FF;
         3'd3:    w_bar_rgb = 16'h07E0;
         3'd4:    w_bar_rgb = 16'hF81F;
         3'd5:    w_bar_rgb = 16'hF800;
         3'd6:    w_bar_rgb = 16'h001F;
         default: w_bar_rgb = 16'h0000;
      endcase
   end

   assign rgb = rgb_valid ? w_bar_rgb : 16'd0;
`else
   // pix_data is the generator's registered reply to last clk's request, aligned with rgb_valid.
   assign rgb = rgb_valid ? pix_data : 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with a reduced raster; expected outputs come from clocks-since-reset
// arithmetic and a stub image generator with a random salt.
module tb_vga_timing_ctrl;

   localparam int H_SYNC = 4, H_BACK = 3, H_VALID = 16, H_FRONT = 2;
   localparam int V_SYNC = 2, V_BACK = 3, V_VALID = 6, V_FRONT = 2;
   localparam int SYNC_NEG = 0;
   localparam int HT = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int VT = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HA = H_SYNC + H_BACK;
   localparam int VA = V_SYNC + V_BACK;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pix_data = 16'd0;
   logic [9:0]  pix_x, pix_y;
   logic        hsync, vsync, rgb_valid;
   logic [15:0] rgb;

   int          n_chk = 0;
   int          n_pass = 0;
   int          t = 0;
   logic [15:0] salt;
   logic [15:0] bar_color [8];

   vga_timing_ctrl #(
      .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_VALID(H_VALID), .H_FRONT(H_FRONT),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_VALID(V_VALID), .V_FRONT(V_FRONT),
      .SYNC_NEG(SYNC_NEG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_data(pix_data),
      .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
      .rgb_valid(rgb_valid), .rgb(rgb)
   );

   always #5 clk = ~clk;

   // Reference timebase: clocks elapsed since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) t <= 0;
      else        t <= t + 1;
   end

   function automatic logic [15:0] stub(input int x, input int y);
      logic [9:0] xv, yv;
      xv = 10'(x);
      yv = 10'(y);
      return {yv[4:0], xv[5:0], yv[4:0]} ^ salt;
   endfunction

   // Stub image generator: registered reply to the current request.
   always @(posedge clk) begin
`ifdef VGA_COLOR_BAR_EN
      pix_data <= 16'h1234;
`else
      pix_data <= (pix_x != 10'h3FF) ? stub(int'(pix_x), int'(pix_y)) : 16'($urandom);
`endif
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s t=%0d got %h want %h", tag, t, obs, exp_v);
   endtask

   task automatic check_now();
      int h, v;
      logic act, s_h, s_v, vact, valid, req;
      logic [15:0] e_rgb;
      logic [9:0]  e_px, e_py;
      act = (SYNC_NEG == 0);
      if (!rst_n) begin
         h = 0; v = 0;
      end else begin
         h = t % HT;
         v = (t / HT) % VT;
      end
      s_h   = (h < H_SYNC) ? act : ~act;
      s_v   = (v < V_SYNC) ? act : ~act;
      vact  = (v >= VA) && (v < VA + V_VALID);
      valid = vact && (h >= HA) && (h < HA + H_VALID);
      req   = vact && (h >= HA - 1) && (h < HA + H_VALID - 1);
      e_px  = req ? 10'(h - (HA - 1)) : 10'h3FF;
      e_py  = req ? 10'(v - VA) : 10'h3FF;
`ifdef VGA_COLOR_BAR_EN
      e_rgb = valid ? bar_color[(h - HA) / (H_VALID / 8)] : 16'd0;
`else
      e_rgb = valid ? stub(h - HA, v - VA) : 16'd0;
`endif
      chk("hsync", 16'(hsync), 16'(s_h));
      chk("vsync", 16'(vsync), 16'(s_v));
      chk("rgb_valid", 16'(rgb_valid), 16'(valid));
      chk("pix_x", 16'(pix_x), 16'(e_px));
      chk("pix_y", 16'(pix_y), 16'(e_py));
      chk("rgb", rgb, e_rgb);
   endtask

   always @(negedge clk) check_now();

   // Asserts reset between edges and checks the outputs settle before the next edge.
   task automatic apply_reset(input int n);
      #2 rst_n = 1'b0;
      #1 check_now();
      repeat (n) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      bar_color[0] = 16'hFFFF; bar_color[1] = 16'hFFE0;
      bar_color[2] = 16'h07FF; bar_color[3] = 16'h07E0;
      bar_color[4] = 16'hF81F; bar_color[5] = 16'hF800;
      bar_color[6] = 16'h001F; bar_color[7] = 16'h0000;
      salt = 16'($urandom);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (FRAME + 5) @(negedge clk);
      repeat (6) begin
         repeat ($urandom_range(40, 2 * FRAME)) @(negedge clk);
         apply_reset($urandom_range(1, 3));
      end
      repeat (2 * FRAME + 10) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
